deserializer_electr_cfg: RTL

Receive end of the electrode-configuration serial link. Samples the MSB-first bitstream qualified by enable_config, checks the frame against the sr_finish end marker, and presents the N_ELECTRODES-bit configuration in parallel. Sits at the electrode-driver side of the link, facing the parallel-to-serial transmitter. The output register updates only on a well-formed frame; malformed frames are discarded and flagged.

---
 rtl/deserializer_electr_cfg.sv | 126 ++++++++++++
 1 files changed

// File: rtl/deserializer_electr_cfg.sv
// Receive end of the electrode-configuration serial link: shifts in an MSB-first
// frame, validates it against the sr_finish marker and commits it in parallel.
//
// state    | meaning
// IDLE     | no frame in progress; a stray sr_finish is flagged
// SHIFT    | enable_config high, bits being collected
// WAIT_FIN | enable_config has fallen, waiting up to FIN_WAIT cycles for sr_finish
module deserializer_electr_cfg #(
    parameter int N_ELECTRODES = 31,
    parameter int FIN_WAIT     = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    serial_in,
    input  logic                    enable_config,
    input  logic                    sr_finish,
    output logic [N_ELECTRODES-1:0] electr_config_out,
    output logic                    config_valid,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int CNT_W = $clog2(N_ELECTRODES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_ELECTRODES);
    localparam logic [3:0]       WAIT_MAX = 4'(FIN_WAIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_FIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [N_ELECTRODES-1:0] r_shift;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [3:0]              r_wait_cnt;
    logic                    r_ovf;
    logic                    w_commit_ok;
    logic [N_ELECTRODES-1:0] w_shift_next;

    assign w_commit_ok  = (r_bit_cnt == CNT_FULL) && !r_ovf;
    assign w_shift_next = {r_shift[N_ELECTRODES-2:0], serial_in};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state           <= IDLE;
            r_shift           <= '0;
            r_bit_cnt         <= '0;
            r_wait_cnt        <= '0;
            r_ovf             <= 1'b0;
            electr_config_out <= '0;
            config_valid      <= 1'b0;
            frame_err         <= 1'b0;
            busy              <= 1'b0;
        end else begin
            config_valid <= 1'b0;
            frame_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sr_finish) begin
                        frame_err <= 1'b1;
                    end else if (enable_config) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= CNT_W'(1);
                        r_ovf     <= 1'b0;
                        r_state   <= SHIFT;
                        busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (enable_config && sr_finish) begin
                        frame_err <= 1'b1;
                        r_state   <= IDLE;
                        busy      <= 1'b0;
                    end else if (enable_config) begin
                        // Extra bits beyond the frame poison it rather than shift
                        if (r_bit_cnt == CNT_FULL) begin
                            r_ovf <= 1'b1;
                        end else if (!r_ovf) begin
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end else if (sr_finish) begin
                        if (w_commit_ok) begin
                            electr_config_out <= r_shift;
                            config_valid      <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_wait_cnt <= 4'd1;
                        r_state    <= WAIT_FIN;
                    end
                end

                WAIT_FIN: begin
                    if (sr_finish) begin
                        if (w_commit_ok) begin
                            electr_config_out <= r_shift;
                            config_valid      <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else if (enable_config || (r_wait_cnt == WAIT_MAX)) begin
                        frame_err <= 1'b1;
                        r_state   <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
